turn_scheduler: RTL and testbench
=================================

TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_MISSES, default 3, the number of consecutive timeouts by one player that forfeits the game (range 1..7).
REQ-002 The block SHALL have parameter FIRST_PLAYER, default 0, the player who moves first in every game (0=P1, 1=P2).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port start, input, 1: single-cycle new-game request.
REQ-007 Port p1_move_valid / p2_move_valid, input, 1 each: player move strobe.
REQ-008 Port p1_col / p2_col, input, 3 each: column chosen, sampled with its strobe.
REQ-009 Port timer_timeout, input, 1: turn-timer expiry flag.
REQ-010 Port timer_enable, output, 1: turn-timer count enable.
REQ-011 Port timer_reset, output, 1: turn-timer clear, single-cycle pulse.
REQ-012 Port drop_req, output, 1: piece-drop request to the board datapath.
REQ-013 Port drop_col, output, 3: column of the drop request.
REQ-014 Port drop_player, output, 1: owner of the dropped piece.
REQ-015 Port drop_ack, input, 1: board accepted or rejected the drop.
REQ-016 Port drop_ok, input, 1: qualifies drop_ack; 1 means placed, 0 means column full.
REQ-017 Port win_detect / board_full, input, 1 each: board status, valid the cycle after drop_ack.
REQ-018 Port current_player, output, 1: player whose turn it is.
REQ-019 Port invalid_move, output, 1: single-cycle pulse on a rejected drop.
REQ-020 Port game_over, output, 1: high while in GAME_OVER.
REQ-021 Port winner, output, 2: 00 none, 01 P1, 10 P2, 11 draw.
REQ-022 Port p1_misses / p2_misses, output, 3 each: consecutive-timeout counts.

Function
REQ-023 The block SHALL implement the states IDLE, TURN_WAIT, DROP, CHECK, SWITCH and GAME_OVER, held in registers.
REQ-024 In IDLE, start SHALL load current_player=FIRST_PLAYER, clear both miss counts and winner, pulse timer_reset for 1 cycle, and go to TURN_WAIT.
REQ-025 In TURN_WAIT, timer_enable SHALL be 1; in every other state it SHALL be 0.
REQ-026 In TURN_WAIT, only the current player's move_valid SHALL be honoured; the other player's strobe SHALL be ignored with no side effect.
REQ-027 On an honoured move, the block SHALL latch its col into drop_col and go to DROP on the next cycle.
REQ-028 If a move and timer_timeout arrive in the same cycle, the move SHALL win and the timeout SHALL be ignored.
REQ-029 On timeout alone, the block SHALL increment the current player's miss count (saturating at 7).
REQ-030 After a timeout, if the new count equals MAX_MISSES, the block SHALL enter GAME_OVER with the opponent as winner; otherwise it SHALL go to SWITCH.
REQ-031 In DROP, drop_req SHALL be held at 1 with drop_col/drop_player stable until drop_ack; there SHALL be no timeout.
REQ-032 On drop_ack with drop_ok=1, the block SHALL clear the current player's miss count and go to CHECK.
REQ-033 On drop_ack with drop_ok=0, the block SHALL pulse invalid_move and return to TURN_WAIT with the same player and no timer_reset, so the remaining turn time is kept.
REQ-034 In CHECK (1 cycle), win_detect SHALL set winner to the current player and enter GAME_OVER.
REQ-035 In CHECK, board_full without a win SHALL set winner=11 (draw) and enter GAME_OVER.
REQ-036 In CHECK, with neither win_detect nor board_full, the block SHALL go to SWITCH.
REQ-037 In SWITCH (1 cycle), the block SHALL toggle current_player, pulse timer_reset, and go to TURN_WAIT.
REQ-038 In GAME_OVER, game_over=1 and winner SHALL hold; start SHALL behave as in IDLE.
REQ-039 A start pulse in TURN_WAIT, DROP, CHECK or SWITCH SHALL be ignored.
REQ-040 drop_req SHALL never be asserted outside DROP.

Reset
REQ-041 While rst_n=0 at a clock edge, the block SHALL enter IDLE with all outputs 0, current_player=0, and miss counts 0, including mid-DROP; an outstanding drop_req SHALL be dropped.

Verification
REQ-042 start, then P1 move col 3, then ack ok, no win -> drop_req one cycle after strobe, drop_col=3, then SWITCH, current_player=1, timer_reset pulse.
REQ-043 P2 strobe during P1 turn -> no drop_req and no state change; simultaneous P1 move and timeout -> drop issued and p1_misses unchanged.
REQ-044 Three consecutive P1 timeouts with P2 moving in between -> game_over=1, winner=10; one P1 move between timeouts -> p1_misses back to 0.
REQ-045 Drop ack with drop_ok=0 -> invalid_move for exactly 1 cycle, same player, no timer_reset.
REQ-046 win_detect in CHECK for P2 -> winner=10; board_full alone -> winner=11; start in GAME_OVER -> new game with FIRST_PLAYER.
REQ-047 rst_n low while in DROP -> drop_req=0 next edge, state IDLE, all counts 0.

Source files
------------

// File: rtl/turn_scheduler.sv
// Turn sequencer for a two-player drop game: alternates turns, issues drop
// requests to the board datapath, counts consecutive timeouts and decides the winner.
module turn_scheduler #(
    parameter int MAX_MISSES   = 3,
    parameter int FIRST_PLAYER = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_move_valid,
    input  logic       p2_move_valid,
    input  logic [2:0] p1_col,
    input  logic [2:0] p2_col,
    input  logic       timer_timeout,
    output logic       timer_enable,
    output logic       timer_reset,
    output logic       drop_req,
    output logic [2:0] drop_col,
    output logic       drop_player,
    input  logic       drop_ack,
    input  logic       drop_ok,
    input  logic       win_detect,
    input  logic       board_full,
    output logic       current_player,
    output logic       invalid_move,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] p1_misses,
    output logic [2:0] p2_misses
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TURN_WAIT = 3'd1,
        DROP      = 3'd2,
        CHECK     = 3'd3,
        SWITCH    = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [2:0] MAX_M = 3'(MAX_MISSES);
    localparam logic       FIRST = 1'(FIRST_PLAYER);

    state_t     state;
    logic       cur_move;
    logic [2:0] cur_col;
    logic [2:0] cur_miss;
    logic [2:0] miss_inc;

    // Only the player on turn is listened to; the other strobe is dropped here.
    assign cur_move = current_player ? p2_move_valid : p1_move_valid;
    assign cur_col  = current_player ? p2_col : p1_col;
    assign cur_miss = current_player ? p2_misses : p1_misses;
    assign miss_inc = (cur_miss == 3'd7) ? 3'd7 : cur_miss + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer_enable   <= 1'b0;
            timer_reset    <= 1'b0;
            drop_req       <= 1'b0;
            drop_col       <= 3'd0;
            drop_player    <= 1'b0;
            current_player <= 1'b0;
            invalid_move   <= 1'b0;
            game_over      <= 1'b0;
            winner         <= 2'b00;
            p1_misses      <= 3'd0;
            p2_misses      <= 3'd0;
        end else begin
            timer_reset  <= 1'b0;
            invalid_move <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        state          <= TURN_WAIT;
                        current_player <= FIRST;
                        p1_misses      <= 3'd0;
                        p2_misses      <= 3'd0;
                        winner         <= 2'b00;
                        game_over      <= 1'b0;
                        timer_reset    <= 1'b1;
                        timer_enable   <= 1'b1;
                    end
                end
                TURN_WAIT: begin
                    // A move in the same cycle as a timeout takes priority.
                    if (cur_move) begin
                        drop_col     <= cur_col;
                        drop_player  <= current_player;
                        drop_req     <= 1'b1;
                        timer_enable <= 1'b0;
                        state        <= DROP;
                    end else if (timer_timeout) begin
                        timer_enable <= 1'b0;
                        if (current_player) p2_misses <= miss_inc;
                        else                p1_misses <= miss_inc;
                        if (miss_inc == MAX_M) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= current_player ? 2'b01 : 2'b10;
                        end else begin
                            state <= SWITCH;
                        end
                    end
                end
                DROP: begin
                    if (drop_ack) begin
                        drop_req <= 1'b0;
                        if (drop_ok) begin
                            if (current_player) p2_misses <= 3'd0;
                            else                p1_misses <= 3'd0;
                            state <= CHECK;
                        end else begin
                            // Retry keeps the running turn timer: no timer_reset.
                            invalid_move <= 1'b1;
                            timer_enable <= 1'b1;
                            state        <= TURN_WAIT;
                        end
                    end
                end
                CHECK: begin
                    if (win_detect) begin
                        winner    <= current_player ? 2'b10 : 2'b01;
                        game_over <= 1'b1;
                        state     <= GAME_OVER;
                    end else if (board_full) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= GAME_OVER;
                    end else begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    current_player <= ~current_player;
                    timer_reset    <= 1'b1;
                    timer_enable   <= 1'b1;
                    state          <= TURN_WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed test of turn_scheduler with default parameters (MAX_MISSES=3, P1 first).
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, start, p1_move_valid, p2_move_valid;
    logic [2:0] p1_col, p2_col;
    logic       timer_timeout, timer_enable, timer_reset;
    logic       drop_req, drop_player, drop_ack, drop_ok;
    logic [2:0] drop_col;
    logic       win_detect, board_full, current_player, invalid_move, game_over;
    logic [1:0] winner;
    logic [2:0] p1_misses, p2_misses;

    int total = 0;
    int bad   = 0;

    turn_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p1_move_valid(p1_move_valid), .p2_move_valid(p2_move_valid),
        .p1_col(p1_col), .p2_col(p2_col), .timer_timeout(timer_timeout),
        .timer_enable(timer_enable), .timer_reset(timer_reset),
        .drop_req(drop_req), .drop_col(drop_col), .drop_player(drop_player),
        .drop_ack(drop_ack), .drop_ok(drop_ok),
        .win_detect(win_detect), .board_full(board_full),
        .current_player(current_player), .invalid_move(invalid_move),
        .game_over(game_over), .winner(winner),
        .p1_misses(p1_misses), .p2_misses(p2_misses)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic p, input logic [2:0] c);
        if (p) begin p2_move_valid = 1'b1; p2_col = c; end
        else   begin p1_move_valid = 1'b1; p1_col = c; end
        tick();
        p1_move_valid = 1'b0;
        p2_move_valid = 1'b0;
    endtask

    task automatic ack(input logic ok);
        drop_ack = 1'b1;
        drop_ok  = ok;
        tick();
        drop_ack = 1'b0;
        drop_ok  = 1'b0;
    endtask

    task automatic timeout();
        timer_timeout = 1'b1;
        tick();
        timer_timeout = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; p1_move_valid = 1'b0; p2_move_valid = 1'b0;
        p1_col = 3'd0; p2_col = 3'd0; timer_timeout = 1'b0;
        drop_ack = 1'b0; drop_ok = 1'b0; win_detect = 1'b0; board_full = 1'b0;
        tick(); tick();
        chk("rst_drop_req", 32'(drop_req), 0);
        chk("rst_tmr_en", 32'(timer_enable), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_cur_player", 32'(current_player), 0);
        rst_n = 1'b1;
        tick();

        // New game, P1 first
        pulse_start();
        chk("start_tmr_rst", 32'(timer_reset), 1);
        chk("start_tmr_en", 32'(timer_enable), 1);
        chk("start_player", 32'(current_player), 0);
        tick();
        chk("tmr_rst_pulse", 32'(timer_reset), 0);

        // Off-turn strobe and mid-turn start ignored
        start = 1'b1;
        move(1'b1, 3'd5);
        start = 1'b0;
        chk("offturn_no_drop", 32'(drop_req), 0);
        chk("offturn_tmr_en", 32'(timer_enable), 1);
        chk("midturn_start_ign", 32'(timer_reset), 0);

        // P1 plays column 3, held until ack
        move(1'b0, 3'd3);
        chk("p1_drop_req", 32'(drop_req), 1);
        chk("p1_drop_col", 32'(drop_col), 3);
        chk("p1_drop_player", 32'(drop_player), 0);
        chk("drop_tmr_en", 32'(timer_enable), 0);
        timer_timeout = 1'b1;
        tick();
        timer_timeout = 1'b0;
        chk("drop_held", 32'(drop_req), 1);
        chk("drop_no_timeout", 32'(p1_misses), 0);
        ack(1'b1);
        chk("check_drop_clr", 32'(drop_req), 0);
        tick();
        tick();
        chk("switch_player", 32'(current_player), 1);
        chk("switch_tmr_rst", 32'(timer_reset), 1);
        chk("switch_tmr_en", 32'(timer_enable), 1);

        // P2 move with simultaneous timeout: move wins
        timer_timeout = 1'b1;
        move(1'b1, 3'd6);
        timer_timeout = 1'b0;
        chk("sim_drop_req", 32'(drop_req), 1);
        chk("sim_drop_col", 32'(drop_col), 6);
        chk("sim_drop_player", 32'(drop_player), 1);
        chk("sim_p2_misses", 32'(p2_misses), 0);

        // Column full -> invalid, same player, no timer reset
        ack(1'b0);
        chk("inv_pulse", 32'(invalid_move), 1);
        chk("inv_drop_clr", 32'(drop_req), 0);
        chk("inv_player", 32'(current_player), 1);
        chk("inv_no_tmr_rst", 32'(timer_reset), 0);
        chk("inv_tmr_en", 32'(timer_enable), 1);
        tick();
        chk("inv_one_cycle", 32'(invalid_move), 0);

        // P2 wins
        move(1'b1, 3'd2);
        ack(1'b1);
        win_detect = 1'b1;
        tick();
        win_detect = 1'b0;
        chk("p2_win_over", 32'(game_over), 1);
        chk("p2_win_winner", 32'(winner), 2);
        tick();
        chk("winner_hold", 32'(winner), 2);

        // Restart from GAME_OVER, then three P1 timeouts
        pulse_start();
        chk("restart_player", 32'(current_player), 0);
        chk("restart_winner", 32'(winner), 0);
        chk("restart_over", 32'(game_over), 0);
        for (int i = 1; i <= 3; i++) begin
            timeout();
            chk("p1_miss_cnt", 32'(p1_misses), 32'(i));
            if (i < 3) begin
                tick();
                move(1'b1, 3'd4);
                ack(1'b1);
                tick();
                tick();
                chk("back_to_p1", 32'(current_player), 0);
            end
        end
        chk("forfeit_over", 32'(game_over), 1);
        chk("forfeit_winner", 32'(winner), 2);
        chk("forfeit_tmr_en", 32'(timer_enable), 0);

        // Miss counts cleared by a successful move; draw on full board
        pulse_start();
        chk("new_p1_misses", 32'(p1_misses), 0);
        timeout();
        tick();
        timeout();
        chk("p2_miss_cnt", 32'(p2_misses), 1);
        tick();
        move(1'b0, 3'd1);
        ack(1'b1);
        chk("p1_miss_cleared", 32'(p1_misses), 0);
        board_full = 1'b1;
        tick();
        board_full = 1'b0;
        chk("draw_over", 32'(game_over), 1);
        chk("draw_winner", 32'(winner), 3);

        // Reset mid-DROP
        pulse_start();
        timeout();
        tick();
        move(1'b1, 3'd7);
        chk("pre_rst_drop", 32'(drop_req), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_drop_abort", 32'(drop_req), 0);
        chk("rst_player0", 32'(current_player), 0);
        chk("rst_p1m", 32'(p1_misses), 0);
        chk("rst_col0", 32'(drop_col), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_tmr_en", 32'(timer_enable), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
